// File: rtl/mult_col_accum.sv
// Column-count accumulator behind the Wallace compressor.
// Ripples a 3-bit carry across columns and hands off the assembled product.
module mult_col_accum #(
  parameter  int NCOLS = 11,
  localparam int PW    = NCOLS + 3,
  localparam int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          col_valid,
  output logic          col_ready,
  input  logic          col_co,
  input  logic          col_s2,
  input  logic          col_s1,
  input  logic          col_last,
  output logic          prod_valid,
  input  logic          prod_ready,
  output logic [PW-1:0] prod
);

  localparam int PIW = $clog2(PW);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   idx_n;
  logic [2:0]      carry;
  logic [2:0]      carry_n;
  logic [PW-1:0]   prod_n;
  logic            ready_n;
  logic            valid_n;

  logic [2:0]      cnt;
  logic [3:0]      sum;
  logic            take;
  logic            at_end;
  logic [PIW-1:0]  bit_pos;
  logic [PIW-1:0]  top_pos;

  assign cnt     = {col_co, col_s2, col_s1};
  assign sum     = 4'(cnt) + 4'(carry);
  assign take    = col_valid && col_ready;
  assign at_end  = col_last || (idx == CW'(NCOLS - 1));
  assign bit_pos = PIW'(idx);
  // Flushed carry lands directly above the final column.
  assign top_pos = PIW'(idx) + PIW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      idx        <= '0;
      carry      <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      col_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      carry      <= carry_n;
      prod       <= prod_n;
      prod_valid <= valid_n;
      col_ready  <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM: if (take && at_end) state_n = FLUSH;
      FLUSH: state_n = HOLD;
      HOLD:  if (prod_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  always_comb begin
    idx_n   = idx;
    carry_n = carry;
    prod_n  = prod;
    unique case (state)
      ACCUM: begin
        if (take) begin
          prod_n[bit_pos] = sum[0];
          carry_n         = sum[3:1];
          if (!at_end) idx_n = idx + CW'(1);
        end
      end
      FLUSH: begin
        prod_n[top_pos +: 3] = carry;
      end
      HOLD: begin
        if (prod_ready) begin
          prod_n  = '0;
          carry_n = '0;
          idx_n   = '0;
        end
      end
      default: begin
        prod_n  = '0;
        carry_n = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Handshake flags are registered from the next state.
  always_comb begin
    ready_n = (state_n == ACCUM);
    valid_n = (state_n == HOLD);
  end

endmodule

// File: tb/tb_mult_col_accum.sv
// Directed bench for mult_col_accum.
// Frames of column counts with hand-computed products.
module tb_mult_col_accum;

  localparam int NCOLS = 11;
  localparam int PW    = NCOLS + 3;

  logic          clk;
  logic          rst_n;
  logic          col_valid;
  logic          col_ready;
  logic          col_co;
  logic          col_s2;
  logic          col_s1;
  logic          col_last;
  logic          prod_valid;
  logic          prod_ready;
  logic [PW-1:0] prod;

  int errs;
  int checks;
  int cols[NCOLS];

  mult_col_accum #(.NCOLS(NCOLS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_co     (col_co),
    .col_s2     (col_s2),
    .col_s1     (col_s1),
    .col_last   (col_last),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_col(input int c, input bit last, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (!col_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!col_ready) chk("ready_timeout", 32'(col_ready), 32'd1);
    col_valid = 1'b1;
    {col_co, col_s2, col_s1} = 3'(c);
    col_last = last;
    @(posedge clk);
    #1;
    col_valid = 1'b0;
    col_last  = 1'b0;
    {col_co, col_s2, col_s1} = 3'd7;
  endtask

  task automatic send_frame(input int n, input bit use_last, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_col(cols[i], use_last && (i == n - 1), gap);
    end
  endtask

  task automatic get_prod(input string tag, input int exp, input int stall);
    chk({tag, "_flush_valid"}, 32'(prod_valid), 32'd0);
    chk({tag, "_flush_ready"}, 32'(col_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(prod_valid), 32'd1);
    chk({tag, "_prod"}, 32'(prod), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(prod_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(col_ready), 32'd0);
      chk({tag, "_hold_prod"}, 32'(prod), 32'(exp));
    end
    prod_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_valid"}, 32'(prod_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(col_ready), 32'd1);
    chk({tag, "_done_prod"}, 32'(prod), 32'd0);
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst_n      = 1'b0;
    col_valid  = 1'b0;
    col_last   = 1'b0;
    {col_co, col_s2, col_s1} = 3'd0;
    prod_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(prod_valid), 32'd0);
    chk("rst_ready", 32'(col_ready), 32'd1);
    chk("rst_prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 63 x 63
    cols = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    send_frame(11, 1'b1, 1'b0);
    get_prod("sq63", 3969, 0);

    // Single-column frame, then all-zero frame ended by column count
    cols[0] = 6;
    send_frame(1, 1'b1, 1'b0);
    get_prod("single", 6, 0);
    cols = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(11, 1'b0, 1'b0);
    get_prod("zero", 0, 0);

    // Backpressure
    cols = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    prod_ready = 1'b0;
    send_frame(11, 1'b1, 1'b0);
    get_prod("bp", 3969, 5);

    // Max counts with random gaps, ended by column count
    cols = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    send_frame(11, 1'b0, 1'b1);
    get_prod("max", 14329, 0);

    // Two-column frame with early last: 5 + 2*3 = 11
    cols[0] = 5;
    cols[1] = 3;
    send_frame(2, 1'b1, 1'b1);
    get_prod("two", 11, 0);

    // Reset mid-frame
    cols = '{7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0};
    send_frame(4, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_ready", 32'(col_ready), 32'd1);
    chk("mrst_prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cols[0] = 6;
    send_frame(1, 1'b1, 1'b0);
    get_prod("after_rst", 6, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
